// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle front-end for the 32-bit combinational ALU.
// Accepts one request at a time, drives the ALU from registered operands,
// gates execution on a condition code evaluated against the NZVC register,
// and holds the captured response until the consumer takes it.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_cond,
  input  logic             req_setflags,
  // ALU interface
  output logic [WIDTH-1:0] alu_reg1,
  output logic [WIDTH-1:0] alu_reg2,
  output logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_c,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_executed,
  output logic             rsp_illegal,
  // architectural state
  output logic [3:0]       flags,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] reg1_q, reg1_d;
  logic [WIDTH-1:0] reg2_q, reg2_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       cond_q, cond_d;
  logic             setflags_q, setflags_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             executed_q, executed_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       flags_q, flags_d;

  logic legal;
  logic pass;
  logic executed;

  // flags register layout is {N,Z,C,V}
  logic flag_n, flag_z, flag_c, flag_v;
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Opcode legality: only the opcodes the ALU actually implements
  always_comb begin
    legal = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b1000, 4'b1001, 4'b1110, 4'b1111: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  // Condition check against the flags as they stand at the start of EXEC
  always_comb begin
    pass = 1'b0;
    case (cond_q)
      4'b0000: pass = flag_z;
      4'b0001: pass = !flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = !flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = !flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = !flag_v;
      4'b1000: pass = flag_c && !flag_z;
      4'b1001: pass = !flag_c || flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = !flag_z && (flag_n == flag_v);
      4'b1101: pass = flag_z || (flag_n != flag_v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign executed = legal && pass;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_d    = state_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    op_d       = op_q;
    cond_d     = cond_q;
    setflags_d = setflags_q;
    result_d   = result_q;
    executed_d = executed_q;
    illegal_d  = illegal_q;
    flags_d    = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          reg1_d     = req_a;
          reg2_d     = req_b;
          op_d       = req_op;
          cond_d     = req_cond;
          setflags_d = req_setflags;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU flags are taken verbatim; only their packing order changes
        result_d   = executed ? alu_result : '0;
        if (executed && setflags_q) begin
          flags_d = {alu_n, alu_z, alu_c, alu_v};
        end
        executed_d = executed;
        illegal_d  = !legal;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wins over any handshake in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      reg1_q     <= '0;
      reg2_q     <= '0;
      op_q       <= 4'b0000;
      cond_q     <= 4'b0000;
      setflags_q <= 1'b0;
      result_q   <= '0;
      executed_q <= 1'b0;
      illegal_q  <= 1'b0;
      flags_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      op_q       <= op_d;
      cond_q     <= cond_d;
      setflags_q <= setflags_d;
      result_q   <= result_d;
      executed_q <= executed_d;
      illegal_q  <= illegal_d;
      flags_q    <= flags_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign busy          = (state_q != ST_IDLE);
  assign alu_reg1      = reg1_q;
  assign alu_reg2      = reg2_q;
  assign alu_operation = op_q;
  assign rsp_result    = result_q;
  assign rsp_executed  = executed_q;
  assign rsp_illegal   = illegal_q;
  assign flags         = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU on the ALU port, scoreboard
// of expected responses pushed at request time and popped on rsp_valid.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_cond;
  logic        req_setflags;
  logic [31:0] alu_reg1, alu_reg2;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_z, alu_n, alu_v, alu_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_executed;
  logic        rsp_illegal;
  logic [3:0]  flags;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ex;
    logic        il;
    logic [3:0]  fl;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  model_flags;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cond(req_cond), .req_setflags(req_setflags),
    .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_executed(rsp_executed), .rsp_illegal(rsp_illegal),
    .flags(flags), .busy(busy)
  );

  // Behavioural ALU: returns {N,Z,C,V,result}. Unimplemented opcodes return
  // a nonzero junk value so a sequencer that forgets to gate it is exposed.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    r = 32'hDEAD_BEEF;
    case (op)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0001: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0010: r = $signed(a) * $signed(b);
      4'b0011: r = (b == 0) ? 32'd0 : $signed(a) / $signed(b);
      4'b0100: r = (b == 0) ? 32'd0 : $signed(a) % $signed(b);
      4'b1000: r = a & b;
      4'b1001: r = a | b;
      4'b1110: r = a << b[4:0];
      4'b1111: r = a >> b[4:0];
      default: r = 32'hDEAD_BEEF;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb begin
    logic [35:0] o;
    o = alu_f(alu_operation, alu_reg1, alu_reg2);
    alu_n      = o[35];
    alu_z      = o[34];
    alu_c      = o[33];
    alu_v      = o[32];
    alu_result = o[31:0];
  end

  // Condition table, flags packed {N,Z,C,V}
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                       4'b1000, 4'b1001, 4'b1110, 4'b1111});
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compute the expected response from the model and push it
  task automatic push_expected(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] cc, input logic sf);
    exp_t        e;
    logic [35:0] o;
    logic        ex;
    o  = alu_f(op, a, b);
    ex = op_legal(op) && cond_ok(cc, model_flags);
    if (ex && sf) model_flags = o[35:32];
    e.res = ex ? o[31:0] : 32'd0;
    e.ex  = ex;
    e.il  = !op_legal(op);
    e.fl  = model_flags;
    sb_q.push_back(e);
  endtask

  // One full transaction: accept, exec, optional response stall, handshake
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] cc, input logic sf,
                       input int stall);
    exp_t e;
    @(negedge clk);
    check({name, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cond = cc; req_setflags = sf;
    push_expected(op, a, b, cc, sf);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, ".exec_req_ready"}, 32'(req_ready), 32'd0);
    check({name, ".alu_reg1"}, alu_reg1, a);
    @(posedge clk);
    @(negedge clk);
    check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({name, ".scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      check({name, ".stall_result"}, rsp_result, e.res);
      check({name, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      check({name, ".stall_req_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check({name, ".result"}, rsp_result, e.res);
    check({name, ".executed"}, 32'(rsp_executed), 32'(e.ex));
    check({name, ".illegal"}, 32'(rsp_illegal), 32'(e.il));
    check({name, ".flags"}, 32'(flags), 32'(e.fl));
    check({name, ".hs_req_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, ".done_valid"}, 32'(rsp_valid), 32'd0);
    $display("op %s op=%b a=%0h b=%0h cc=%b sf=%0d -> res=%0h ex=%0d il=%0d flags=%b",
             name, op, a, b, cc, sf, e.res, e.ex, e.il, e.fl);
  endtask

  logic [3:0] op_tab [10];

  initial begin
    op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
               4'b1000, 4'b1001, 4'b1110, 4'b1111, 4'b0110};
    model_flags = 4'b0000;
    rst = 1'b1; req_valid = 1'b1; req_op = 4'b0000; req_a = 32'h55; req_b = 32'h1;
    req_cond = 4'b1110; req_setflags = 1'b1; rsp_ready = 1'b1;

    // Reset held two cycles with a request pending: nothing may be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    check("reset.flags", 32'(flags), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.alu_reg1", alu_reg1, 32'd0);
    check("reset.rsp_result", rsp_result, 32'd0);
    $display("reset released");

    do_op("sub_eq", 4'b0001, 32'd5, 32'd5, 4'b1110, 1'b1, 0);
    check("sub_eq.flags_z", 32'(flags), 32'b0100);
    do_op("add_ne", 4'b0000, 32'd1, 32'd2, 4'b0001, 1'b0, 0);
    do_op("add_eq", 4'b0000, 32'd1, 32'd2, 4'b0000, 1'b0, 0);
    do_op("illegal", 4'b0101, 32'd9, 32'd9, 4'b1110, 1'b1, 0);
    do_op("mul_bp", 4'b0010, 32'd7, -32'sd3, 4'b1110, 1'b1, 5);
    do_op("lt_pass", 4'b0000, 32'd10, 32'd20, 4'b1011, 1'b0, 0);
    do_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, 4'b1110, 1'b1, 1);
    do_op("ge_fail", 4'b1001, 32'hF0, 32'h0F, 4'b1010, 1'b1, 0);
    do_op("nv", 4'b0000, 32'd1, 32'd1, 4'b1111, 1'b1, 0);

    // Randomised mix of opcodes (including an illegal one) and conditions
    for (int i = 0; i < 24; i++) begin
      do_op($sformatf("rnd%0d", i), op_tab[$urandom_range(0, 9)], $urandom(),
            32'($urandom_range(0, 40)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    // Reset during EXEC: op dropped, flags cleared
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0000; req_a = 32'd100; req_b = 32'd200;
    req_cond = 4'b1110; req_setflags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst.in_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_flags = 4'b0000;
    check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst.flags", 32'(flags), 32'd0);
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("midrst.still_no_rsp", 32'(rsp_valid), 32'd0);
    $display("reset during exec applied");
    do_op("add_after_rst", 4'b0000, 32'd2, 32'd2, 4'b1110, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
